mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum wait cycles for mem_ack; 0 disables the timeout.
REQ-003 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port op  in  3: access size. 001 word, 010 byte signed, 011 half signed, 100 byte unsigned, 101 half unsigned; other codes mean word.
REQ-006 SHALL have ports mem_read / mem_write  in  1 each: access request from the pipeline; mem_read has priority when both are high.
REQ-007 SHALL have ports addr  in  ADDR_W (byte address) and wdata  in  32 (store data, right-aligned).
REQ-008 SHALL have ports rdata  out  32 (extended load result), done  out  1, stall  out  1, misalign  out  1, bus_err  out  1.
REQ-009 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  ADDR_W (word-aligned, bits [1:0]=0), mem_be  out  4, mem_wdata  out  32.
REQ-010 SHALL have ports mem_ack  in  1 and mem_rdata  in  32 (valid when mem_ack=1).

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-012 start SHALL be (mem_read|mem_write) in IDLE with an aligned address; word accesses need addr[1:0]=0, half accesses need addr[0]=0, byte accesses are always aligned.
REQ-013 On a misaligned request in IDLE, misalign SHALL be 1 combinationally, stall SHALL be 0, no bus access SHALL occur, and the state SHALL remain IDLE.
REQ-014 On start, the unit SHALL enter BUSY and register the following at that edge: mem_req=1, mem_we=!mem_read, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_be, mem_wdata, op and addr[1:0].
REQ-015 stall SHALL be 1 when in IDLE with start, and 1 throughout BUSY; otherwise stall SHALL be 0.
REQ-016 In BUSY, outputs SHALL be held stable until mem_ack=1; on mem_ack the unit SHALL drop mem_req/mem_we next cycle, enter RESP, and register rdata.
REQ-017 In RESP, done SHALL be 1 for exactly one cycle, and the unit SHALL return to IDLE; new requests SHALL be ignored in RESP.
REQ-018 Minimum latency SHALL be 2 cycles from start to done (ack in the first BUSY cycle).
REQ-019 Store lanes SHALL be: byte -> mem_be=1<<addr[1:0], wdata[7:0] replicated to all 4 bytes; half -> mem_be=0011<<(2*addr[1]), wdata[15:0] replicated twice; word -> mem_be=1111.
REQ-020 Load extraction SHALL be: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16]; the result is sign- or zero-extended per op.
REQ-021 On a store completion, rdata SHALL be 0.
REQ-022 Timeout: with TIMEOUT>0, the BUSY cycle counter SHALL reach TIMEOUT without ack, then the unit SHALL drop mem_req, enter RESP with bus_err=1 and rdata=0; bus_err SHALL be high only in RESP.
REQ-023 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and bus_err SHALL be 0.
REQ-024 The wait counter SHALL saturate, never wrap, and clear on BUSY entry.
REQ-025 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-026 rst SHALL force IDLE immediately, independent of clk.
REQ-027 rst SHALL zero mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, done, bus_err and the counter.
REQ-028 Reset during BUSY SHALL abandon the access: mem_req=0 with no done pulse, and the first request after reset release SHALL be accepted normally.

Structure
REQ-029 Op encodings, the state enum and the lane width constant SHALL live in shared package mem_access_pkg.
REQ-030 Byte-lane steering and extension SHALL be a combinational sub-module mem_lane_align, instanced once for loads and once for stores.
REQ-031 The FSM and the counter SHALL remain in mem_access_unit.

Verification
REQ-032 Scenario: lb at addr 0x103 with mem_rdata=0x80FF_1234, ack after 3 cycles -> rdata=0xFFFF_FF80, done one cycle, stall high 4 cycles.
REQ-033 Scenario: sh at addr 0x202 with wdata=0x0000_BEEF -> mem_addr=0x200, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1 until ack.
REQ-034 Scenario: lw at addr 0x101 -> misalign=1, stall=0, mem_req stays 0.
REQ-035 Scenario: TIMEOUT=4 with no ack -> mem_req drops after 4 BUSY cycles, bus_err=1 and done=1 in the same cycle, rdata=0; repeat with ack on cycle 4 -> bus_err=0.
REQ-036 Scenario: rst pulse mid-BUSY -> mem_req=0 asynchronously, no done; a following lhu at 0x2 with mem_rdata=0xA5A5_0000 -> rdata=0x0000_A5A5.
REQ-037 Scenario: mem_read and mem_write both high with op=001 -> read performed, mem_we=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: op encodings, FSM states,
// access sizes and the small decode helpers used by the unit and lane aligner.
package mem_access_pkg;

  localparam logic [2:0] OP_WORD = 3'b001;
  localparam logic [2:0] OP_LB   = 3'b010;
  localparam logic [2:0] OP_LH   = 3'b011;
  localparam logic [2:0] OP_LBU  = 3'b100;
  localparam logic [2:0] OP_LHU  = 3'b101;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  // Undefined op codes fall back to a word access.
  function automatic size_t op_size(input logic [2:0] op);
    size_t sz;
    case (op)
      OP_LB, OP_LBU: sz = SZ_BYTE;
      OP_LH, OP_LHU: sz = SZ_HALF;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [1:0] off);
    logic ok;
    case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input size_t sz, input logic [1:0] off);
    logic [LANES-1:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational byte-lane steering: LOAD=1 extracts and extends a sub-word
// from a bus word, LOAD=0 replicates right-aligned store data across lanes.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter bit LOAD = 1'b1
) (
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  size_t       size_s;
  logic        sign_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_s;
  logic [31:0] store_s;

  // Lane selection, extension and replication for both directions.
  always_comb begin
    size_s  = op_size(op);
    sign_s  = op_signed(op);
    byte_s  = data_in[{offset, 3'b000} +: LANE_W];
    half_s  = offset[1] ? data_in[31:16] : data_in[15:0];
    load_s  = data_in;
    store_s = data_in;
    case (size_s)
      SZ_BYTE: begin
        load_s  = {{24{sign_s & byte_s[7]}}, byte_s};
        store_s = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        load_s  = {{16{sign_s & half_s[15]}}, half_s};
        store_s = {2{data_in[15:0]}};
      end
      default: begin
        load_s  = data_in;
        store_s = data_in;
      end
    endcase
    data_out = LOAD ? load_s : store_s;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-to-memory access unit: accepts aligned load/store requests, drives a
// word-addressed bus with byte enables, waits for ack (with timeout) and returns.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [1:0]       off_r;
  logic             req_s;
  logic             aligned_s;
  logic             start_s;
  logic             timeout_s;
  size_t            req_size_s;
  logic [31:0]      store_data_s;
  logic [31:0]      load_data_s;

  mem_lane_align #(.LOAD(1'b0)) u_store_align (
    .op       (op),
    .offset   (addr[1:0]),
    .data_in  (wdata),
    .data_out (store_data_s)
  );

  mem_lane_align #(.LOAD(1'b1)) u_load_align (
    .op       (op_r),
    .offset   (off_r),
    .data_in  (mem_rdata),
    .data_out (load_data_s)
  );

  // Request decode; misalign and stall answer the pipeline in the same cycle.
  always_comb begin
    req_s      = mem_read | mem_write;
    req_size_s = op_size(op);
    aligned_s  = is_aligned(req_size_s, addr[1:0]);
    start_s    = (state_r == ST_IDLE) && req_s && aligned_s;
    misalign   = (state_r == ST_IDLE) && req_s && !aligned_s;
    stall      = start_s || (state_r == ST_BUSY);
    timeout_s  = (TIMEOUT > 0) && (cnt_r == CNT_LAST);
  end

  // Next-state logic; ack takes precedence over a simultaneous timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) next_state_s = ST_BUSY;
        else         next_state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (mem_ack || timeout_s) next_state_s = ST_RESP;
        else                      next_state_s = ST_BUSY;
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Bus request, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      rdata     <= 32'h0000_0000;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      cnt_r     <= '0;
      op_r      <= OP_WORD;
      off_r     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done    <= 1'b0;
          bus_err <= 1'b0;
          if (start_s) begin
            mem_req   <= 1'b1;
            mem_we    <= ~mem_read;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= lane_mask(req_size_s, addr[1:0]);
            mem_wdata <= store_data_s;
            op_r      <= op;
            off_r     <= addr[1:0];
            cnt_r     <= '0;
          end
        end
        ST_BUSY: begin
          if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b0;
            rdata   <= mem_we ? 32'h0000_0000 : load_data_s;
          end else if (timeout_s) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= 32'h0000_0000;
          end
        end
        ST_RESP: begin
          done    <= 1'b0;
          bus_err <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= 1'b0;
          bus_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=4); each task
// drives one scenario at negedges and compares against hand-computed values.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        done, stall, misalign, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    rst = 1'b1; op = OP_WORD; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, done, bus_err, stall, misalign} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {mem_req, mem_we, done, bus_err, stall, misalign});
    end
    n_checks++;
    if ({mem_addr, mem_be, mem_wdata, rdata} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_regs: addr %h be %b wdata %h rdata %h expected all zero", mem_addr, mem_be, mem_wdata, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input logic [2:0] lop, input logic [31:0] a,
                          input logic [31:0] bus_word, input int ack_cycle, input logic [31:0] exp);
    int stall_cnt = 0;
    mem_read = 1'b1; op = lop; addr = a;
    #1;
    if (stall === 1'b1) stall_cnt++;
    for (int k = 1; k <= ack_cycle; k++) begin
      @(negedge clk);
      mem_read = 1'b0;
      if (k == 1) begin
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== (a & 32'hFFFF_FFFC)) begin
          n_fail++;
          $display("FAIL %s_bus: req %b we %b addr %h expected 1 0 %h", name, mem_req, mem_we, mem_addr, a & 32'hFFFF_FFFC);
        end
      end
      if (stall === 1'b1) stall_cnt++;
      if (k == ack_cycle) begin
        mem_ack = 1'b1; mem_rdata = bus_word;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || rdata !== exp || mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_resp: done %b rdata %h req %b stall %b expected 1 %h 0 0", name, done, rdata, mem_req, stall, exp);
    end
    n_checks++;
    if (stall_cnt != ack_cycle + 1) begin
      n_fail++;
      $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, ack_cycle + 1);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done %b expected 0", name, done);
    end
  endtask

  task automatic test_load();
    run_load("lb",  OP_LB,   32'h0000_0103, 32'h80FF_1234, 3, 32'hFFFF_FF80);
    run_load("lbu", OP_LBU,  32'h0000_0101, 32'h80FF_1234, 1, 32'h0000_0012);
    run_load("lh",  OP_LH,   32'h0000_0102, 32'h80FF_1234, 2, 32'hFFFF_80FF);
    run_load("lw",  OP_WORD, 32'h0000_0104, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
  endtask

  task automatic run_timeout(input bit ack4);
    mem_read = 1'b1; op = OP_WORD; addr = 32'h0000_0300;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      mem_read = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1 || bus_err !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: req %b err %b done %b expected 1 0 0", k, mem_req, bus_err, done);
      end
      if (ack4 && k == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (ack4) begin
      if (mem_req !== 1'b0 || bus_err !== 1'b0 || done !== 1'b1 || rdata !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL ack_at_limit: req %b err %b done %b rdata %h expected 0 0 1 12345678", mem_req, bus_err, done, rdata);
      end
    end else begin
      if (mem_req !== 1'b0 || bus_err !== 1'b1 || done !== 1'b1 || rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL timeout_resp: req %b err %b done %b rdata %h expected 0 1 1 00000000", mem_req, bus_err, done, rdata);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus_err !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err %b done %b expected 0 0", bus_err, done);
    end
  endtask

  task automatic test_timeout();
    run_timeout(1'b0);
    run_timeout(1'b1);
  endtask

  task automatic run_store(input string name, input logic [2:0] sop, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    mem_write = 1'b1; op = sop; addr = a; wdata = d;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      mem_write = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr || mem_be !== exp_be || mem_wdata !== exp_wdata) begin
        n_fail++;
        $display("FAIL %s_bus%0d: req %b we %b addr %h be %b wdata %h expected 1 1 %h %b %h",
                 name, k, mem_req, mem_we, mem_addr, mem_be, mem_wdata, exp_addr, exp_be, exp_wdata);
      end
      if (k == 2) mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || rdata !== 32'h0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_resp: done %b rdata %h req %b we %b expected 1 00000000 0 0", name, done, rdata, mem_req, mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    run_store("sh", OP_LH,   32'h0000_0202, 32'h0000_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    run_store("sb", OP_LB,   32'h0000_0201, 32'h1234_56AB, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
    run_store("sw", OP_WORD, 32'h0000_030C, 32'h1122_3344, 32'h0000_030C, 4'b1111, 32'h1122_3344);
  endtask

  task automatic test_misalign();
    mem_read = 1'b1; op = OP_WORD; addr = 32'h0000_0101; mem_ack = 1'b1;
    #1;
    n_checks++;
    if (misalign !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misalign: misalign %b stall %b expected 1 0", misalign, stall);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_misalign_hold: req %b done %b misalign %b expected 0 0 1", mem_req, done, misalign);
    end
    mem_read = 1'b0; mem_write = 1'b1; op = OP_LH; addr = 32'h0000_0203; mem_ack = 1'b0;
    #1;
    n_checks++;
    if (misalign !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_misalign: misalign %b stall %b expected 1 0", misalign, stall);
    end
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_idle: req %b misalign %b expected 0 0", mem_req, misalign);
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    mem_read = 1'b1; mem_write = 1'b1; op = OP_WORD; addr = 32'h0000_0500; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111) begin
      n_fail++;
      $display("FAIL rw_priority: req %b we %b be %b expected 1 0 1111", mem_req, mem_we, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rw_priority_resp: done %b rdata %h expected 1 deadbeef", done, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    mem_read = 1'b1; op = OP_WORD; addr = 32'h0000_0600;
    @(negedge clk);
    mem_read = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre: req %b expected 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req %b stall %b expected 0 0", mem_req, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (done !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_done%0d: done %b req %b expected 0 0", k, done, mem_req);
      end
      @(negedge clk);
    end
    mem_read = 1'b1; op = OP_LHU; addr = 32'h0000_0002;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lhu_start: stall %b expected 1", stall);
    end
    @(negedge clk);
    mem_read = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lhu_bus: req %b addr %h be %b expected 1 00000000 1100", mem_req, mem_addr, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (done !== 1'b1 || rdata !== 32'h0000_A5A5) begin
      n_fail++;
      $display("FAIL lhu_resp: done %b rdata %h expected 1 0000a5a5", done, rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_timeout();
    test_store();
    test_misalign();
    test_priority();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
